spi_target: RTL and testbench

SPI mode-0 target (peripheral side) for byte-oriented links against an external SPI initiator, such as a host adapter or the SD-style master used on the board. It oversamples `sclk`, `cs_n` and `mosi` with the system clock, shifts bytes MSB-first and exposes them as valid/ready byte streams to the core. It also serves as the bench counterpart for our SPI initiator.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_target_sync_edge.sv | 49 ++++
 rtl/spi_target.sv | 167 ++++++++++++++++
 tb/tb_spi_target.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Brief    : Shared types and constants for the SPI target and initiator.
//  Revision : 1.0  initial release
// ============================================================================
package spi_pkg;

    typedef logic [7:0] byte_t;
    typedef logic [2:0] bitcnt_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam byte_t SPI_DEFAULT_IDLE_BYTE = 8'hFF;

    // Mode 0: clock idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_target_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge
//  Brief    : Multi-stage synchronizer with registered rise/fall pulses.
//  Revision : 1.0  initial release
// ============================================================================
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES:0]   r_vld;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    // Edges are reported only once both samples come from the real input, so
    // the reset value of the chain can never fake a transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_vld  <= '0;
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_vld  <= {r_vld[SYNC_STAGES-1:0], 1'b1};
            r_prev <= w_level;
            r_rise <= r_vld[SYNC_STAGES] &  w_level & ~r_prev;
            r_fall <= r_vld[SYNC_STAGES] & ~w_level &  r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule : sync_edge
`default_nettype wire

// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
//  Module   : spi_target
//  Brief    : Oversampled SPI mode-0 target with valid/ready byte streams.
//  Revision : 1.0  initial release
// ============================================================================
module spi_target
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter byte_t       IDLE_BYTE   = SPI_DEFAULT_IDLE_BYTE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       overrun,
    output logic       underrun,
    input  logic       err_clr,
    output logic       busy
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    bitcnt_t                r_bitcnt;
    logic [6:0]             r_rx_shift;
    byte_t                  r_rx_data;
    logic                   r_rx_valid;
    byte_t                  r_tx_hold;
    logic                   r_hold_full;
    logic [6:0]             r_tx_shift;
    logic                   r_miso;
    logic                   r_overrun;
    logic                   r_underrun;

    logic  w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic  w_start, w_stop, w_in_active, w_rise_ev, w_fall_ev;
    logic  w_load, w_shift, w_byte_done, w_rx_accept, w_tx_accept;
    byte_t w_load_byte, w_rx_byte;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clock   (clock),
        .reset   (reset),
        .i_async (sclk),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clock   (clock),
        .reset   (reset),
        .i_async (cs_n),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_cs_fall) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_cs_rise) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state == ST_ACTIVE);
        miso_en = (r_state == ST_ACTIVE);
    end

    // ------------------------------------------------------------ events
    assign w_start     = (r_state == ST_IDLE)   && w_cs_fall;
    assign w_stop      = (r_state == ST_ACTIVE) && w_cs_rise;
    assign w_in_active = (r_state == ST_ACTIVE) && !w_cs_rise;
    assign w_rise_ev   = w_in_active && w_sclk_rise;
    assign w_fall_ev   = w_in_active && w_sclk_fall;
    assign w_load      = w_start || (w_fall_ev && (r_bitcnt == 3'd0));
    assign w_shift     = w_fall_ev && (r_bitcnt != 3'd0);
    assign w_byte_done = w_rise_ev && (r_bitcnt == 3'd7);
    assign w_rx_byte   = {r_rx_shift, r_mosi_sync[SYNC_STAGES-1]};
    assign w_rx_accept = w_byte_done && (!r_rx_valid || rx_ready);
    // Only an empty holding register accepts, so a shifter load in the same
    // cycle can never race a fresh byte out of the holding register.
    assign w_tx_accept = tx_valid && !r_hold_full;
    assign w_load_byte = r_hold_full ? r_tx_hold : IDLE_BYTE;

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mosi_sync <= {SYNC_STAGES{1'b1}};
            r_bitcnt    <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_hold   <= '0;
            r_hold_full <= 1'b0;
            r_tx_shift  <= '1;
            r_miso      <= 1'b1;
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};

            if (w_start || w_stop) r_bitcnt <= '0;
            else if (w_rise_ev)    r_bitcnt <= r_bitcnt + 3'd1;

            if (w_stop)         r_rx_shift <= '0;
            else if (w_rise_ev) r_rx_shift <= w_rx_byte[6:0];

            if (w_rx_accept) begin
                r_rx_data  <= w_rx_byte;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (w_tx_accept) begin
                r_hold_full <= 1'b1;
                r_tx_hold   <= tx_data;
            end

            if (w_stop) begin
                r_miso     <= 1'b1;
                r_tx_shift <= '1;
            end else if (w_load) begin
                r_miso     <= w_load_byte[7];
                r_tx_shift <= w_load_byte[6:0];
            end else if (w_shift) begin
                r_miso     <= r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[5:0], 1'b1};
            end

            if (w_byte_done && !w_rx_accept) r_overrun <= 1'b1;
            else if (err_clr)                r_overrun <= 1'b0;

            if (w_load && !r_hold_full) r_underrun <= 1'b1;
            else if (err_clr)           r_underrun <= 1'b0;
        end
    end

    assign miso     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_ready = !r_hold_full;
    assign overrun  = r_overrun;
    assign underrun = r_underrun;

endmodule : spi_target
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_target
//  Brief    : Directed self-checking bench for spi_target.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_target;

    localparam int HALF = 6;   // system clocks per sclk phase
    localparam int SEL  = 8;   // clocks between cs_n edge and first sclk

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b1;
    logic       miso, miso_en, rx_valid, tx_ready, overrun, underrun, busy;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       err_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mi, mi2, mi3;
    logic       b;

    spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .clock    (clock),
        .reset    (reset),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_en  (miso_en),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .overrun  (overrun),
        .underrun (underrun),
        .err_clr  (err_clr),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic select();
        cs_n = 1'b0;
        tick(SEL);
    endtask

    task automatic deselect();
        tick(HALF);
        cs_n = 1'b1;
        tick(SEL);
    endtask

    // Mode 0: set mosi in the low phase, sample miso just before sclk rises.
    task automatic xfer_bit(input logic bo, output logic bi);
        mosi = bo;
        tick(HALF);
        bi   = miso;
        sclk = 1'b1;
        tick(HALF);
        sclk = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] mo, output logic [7:0] mo_in);
        logic bit_in;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(mo[i], bit_in);
            mo_in[i] = bit_in;
        end
    endtask

    task automatic queue_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
    endtask

    initial begin
        tick(4);
        reset = 1'b0;
        tick(1);
        check("rst_miso",     miso,     1);
        check("rst_miso_en",  miso_en,  0);
        check("rst_rx_data",  rx_data,  0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_overrun",  overrun,  0);
        check("rst_underrun", underrun, 0);
        check("rst_busy",     busy,     0);

        // Basic byte: A5 out, 3C in; a second byte keeps the boundary reload fed.
        queue_tx(8'hA5);
        check("t1_tx_full", tx_ready, 0);
        select();
        check("t1_busy",    busy,     1);
        check("t1_miso_en", miso_en,  1);
        check("t1_tx_free", tx_ready, 1);
        queue_tx(8'h5A);
        xfer_byte(8'h3C, mi);
        deselect();
        check("t1_miso",     mi,       8'hA5);
        check("t1_rx_data",  rx_data,  8'h3C);
        check("t1_rx_valid", rx_valid, 1);
        check("t1_underrun", underrun, 0);
        check("t1_idle",     busy,     0);
        pop_rx();
        check("t1_popped", rx_valid, 0);

        // Empty TX queue for a 3-byte frame.
        select();
        xfer_byte(8'h00, mi);
        xfer_byte(8'h00, mi2);
        xfer_byte(8'h00, mi3);
        deselect();
        check("t2_miso0",    mi,       8'hFF);
        check("t2_miso1",    mi2,      8'hFF);
        check("t2_miso2",    mi3,      8'hFF);
        check("t2_underrun", underrun, 1);
        check("t2_overrun",  overrun,  1);
        clear_err();
        check("t2_ur_clr", underrun, 0);
        check("t2_or_clr", overrun,  0);
        pop_rx();

        // Overrun: 11 then 22 with no consumer.
        select();
        xfer_byte(8'h11, mi);
        xfer_byte(8'h22, mi);
        deselect();
        check("t3_rx_data", rx_data,  8'h11);
        check("t3_overrun", overrun,  1);
        check("t3_valid",   rx_valid, 1);
        pop_rx();
        check("t3_popped", rx_valid, 0);
        clear_err();

        // Aborted frame after 5 bits, then a full 0x80.
        select();
        for (int i = 0; i < 5; i++) xfer_bit(1'b1, b);
        deselect();
        check("t4_no_partial", rx_valid, 0);
        select();
        xfer_byte(8'h80, mi);
        deselect();
        check("t4_rx_data", rx_data,  8'h80);
        check("t4_valid",   rx_valid, 1);
        check("t4_overrun", overrun,  0);
        pop_rx();
        clear_err();

        // Back-to-back TX with tx_valid held until each byte is taken.
        rx_ready = 1'b1;
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        tick(1);
        check("t5_ready_lo0", tx_ready, 0);
        tx_data = 8'h02;
        select();
        tx_valid = 1'b0;
        check("t5_ready_lo1", tx_ready, 0);
        xfer_byte(8'h01, mi);
        xfer_byte(8'h02, mi2);
        deselect();
        rx_ready = 1'b0;
        check("t5_miso0",    mi,       8'h01);
        check("t5_miso1",    mi2,      8'h02);
        check("t5_ready_hi", tx_ready, 1);
        check("t5_rx_data",  rx_data,  8'h02);
        check("t5_overrun",  overrun,  0);
        clear_err();

        // Reset mid-byte with cs_n held low.
        select();
        for (int i = 0; i < 3; i++) xfer_bit(1'b0, b);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("t6_miso",     miso,     1);
        check("t6_miso_en",  miso_en,  0);
        check("t6_rx_data",  rx_data,  0);
        check("t6_rx_valid", rx_valid, 0);
        check("t6_tx_ready", tx_ready, 1);
        check("t6_overrun",  overrun,  0);
        check("t6_underrun", underrun, 0);
        check("t6_busy",     busy,     0);
        xfer_byte(8'hC3, mi);
        tick(HALF);
        check("t6_ign_valid",    rx_valid, 0);
        check("t6_ign_busy",     busy,     0);
        check("t6_ign_underrun", underrun, 0);
        cs_n = 1'b1;
        tick(SEL);
        select();
        xfer_byte(8'h96, mi);
        deselect();
        check("t6_rx_data2", rx_data,  8'h96);
        check("t6_valid2",   rx_valid, 1);
        check("t6_miso2",    mi,       8'hFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_spi_target
`default_nettype wire
